// File: rtl/cb_n_branch.sv
// One-to-N branch buffer: a circular FIFO whose head word is offered to one channel
// (unicast), to all channels (broadcast), or discarded when its selector is out of range.
module cb_n_branch #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SEL_W  = $clog2(N_OUT)
) (
    input  logic                    CLK,
    input  logic                    MR,
    input  logic                    CB_Send_in,
    input  logic [DATA_W-1:0]       CB_Data_in,
    input  logic [SEL_W-1:0]        CB_Br,
    input  logic                    CB_Bc,
    output logic                    CB_Ack_out,
    output logic [N_OUT-1:0]        CB_Send_out,
    output logic [DATA_W-1:0]       CB_Data_out,
    input  logic [N_OUT-1:0]        CB_Ack_in,
    output logic                    CB_Err,
    output logic [$clog2(DEPTH):0]  CB_Count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [SEL_W-1:0]  br_mem   [DEPTH];
    logic              bc_mem   [DEPTH];

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [N_OUT-1:0] done_q, done_d;

    logic              not_empty;
    logic              push, pop;
    logic [DATA_W-1:0] hd_data;
    logic [SEL_W-1:0]  hd_br;
    logic              hd_bc;
    logic              sel_bad;
    logic [N_OUT-1:0]  one_hot;
    logic [N_OUT-1:0]  send;
    logic [N_OUT-1:0]  accepted;
    logic              err;

    assign not_empty = (count_q != '0);
    assign hd_data   = data_mem[head_q];
    assign hd_br     = br_mem[head_q];
    assign hd_bc     = bc_mem[head_q];
    // Only reachable when N_OUT is not a power of two.
    assign sel_bad   = (32'(hd_br) >= N_OUT);
    assign one_hot   = N_OUT'(1) << hd_br;

    assign CB_Ack_out = (count_q != CW'(DEPTH));
    assign push       = CB_Send_in & CB_Ack_out;

    always_comb begin
        send = '0;
        err  = 1'b0;
        if (not_empty) begin
            if (hd_bc) begin
                send = ~done_q;
            end else if (sel_bad) begin
                err = 1'b1;
            end else begin
                send = one_hot;
            end
        end
    end

    // Acks on channels not currently offered are masked out here.
    assign accepted = send & CB_Ack_in;

    always_comb begin
        pop    = 1'b0;
        done_d = done_q;
        if (not_empty) begin
            if (hd_bc) begin
                if (&(done_q | accepted)) begin
                    pop    = 1'b1;
                    done_d = '0;
                end else begin
                    done_d = done_q | accepted;
                end
            end else begin
                pop = err | (|accepted);
            end
        end
    end

    always_comb begin
        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Storage is qualified by the count, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            data_mem[tail_q] <= CB_Data_in;
            br_mem[tail_q]   <= CB_Br;
            bc_mem[tail_q]   <= CB_Bc;
        end
    end

    assign CB_Send_out = send;
    assign CB_Err      = err;
    assign CB_Data_out = not_empty ? hd_data : '0;
    assign CB_Count    = count_q;

endmodule

// File: tb/tb_cb_n_branch.sv
// Bench for cb_n_branch: directed scenarios plus randomized traffic checked against a
// queue-based reference model; a second N_OUT=3 instance exercises the invalid selector.
module tb_cb_n_branch;

    localparam int N = 4;
    localparam int D = 4;

    logic       CLK = 1'b0;
    logic       MR;
    logic       send_in;
    logic [7:0] data_in;
    logic [1:0] br;
    logic       bc;
    logic [3:0] ack_in;
    logic       ack_out;
    logic [3:0] send_out;
    logic [7:0] data_out;
    logic       err;
    logic [2:0] count;

    logic       s3_send;
    logic [7:0] s3_data;
    logic [1:0] s3_br;
    logic       s3_bc;
    logic [2:0] s3_ack_in;
    logic       s3_ack_out;
    logic [2:0] s3_send_out;
    logic [7:0] s3_data_out;
    logic       s3_err;
    logic [2:0] s3_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] data;
        logic [1:0] br;
        logic       bc;
    } ent_t;

    ent_t       q[$];
    logic [3:0] done_m;

    cb_n_branch u_dut (
        .CLK         (CLK),
        .MR          (MR),
        .CB_Send_in  (send_in),
        .CB_Data_in  (data_in),
        .CB_Br       (br),
        .CB_Bc       (bc),
        .CB_Ack_out  (ack_out),
        .CB_Send_out (send_out),
        .CB_Data_out (data_out),
        .CB_Ack_in   (ack_in),
        .CB_Err      (err),
        .CB_Count    (count)
    );

    cb_n_branch #(.N_OUT(3)) u_dut3 (
        .CLK         (CLK),
        .MR          (MR),
        .CB_Send_in  (s3_send),
        .CB_Data_in  (s3_data),
        .CB_Br       (s3_br),
        .CB_Bc       (s3_bc),
        .CB_Ack_out  (s3_ack_out),
        .CB_Send_out (s3_send_out),
        .CB_Data_out (s3_data_out),
        .CB_Ack_in   (s3_ack_in),
        .CB_Err      (s3_err),
        .CB_Count    (s3_count)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit s, input logic [7:0] d, input logic [1:0] b, input bit c,
                         input logic [3:0] a);
        send_in = s;
        data_in = d;
        br      = b;
        bc      = c;
        ack_in  = a;
    endtask

    // Called just after a falling edge; checks the model, advances one clock, returns
    // after the next falling edge.
    task automatic step(input bit do_rst);
        logic [3:0] es;
        logic       ee;
        logic [7:0] ed;
        logic [3:0] acc;
        bit         pop;
        bit         push;
        ent_t       e;
        if (do_rst) begin
            #2 MR = 1'b1;
            #1;
            check_eq("rst_send", send_out, 0);
            check_eq("rst_err", err, 0);
            check_eq("rst_count", count, 0);
            check_eq("rst_ack", ack_out, 1);
            check_eq("rst_data", data_out, 0);
            q.delete();
            done_m = '0;
            #1 MR = 1'b0;
        end
        es = '0;
        ee = 1'b0;
        ed = '0;
        if (q.size() > 0) begin
            ed = q[0].data;
            if (q[0].bc) es = ~done_m;
            else if (int'(q[0].br) < N) es = 4'(1 << q[0].br);
            else ee = 1'b1;
        end
        check_eq("send", send_out, es);
        check_eq("err", err, ee);
        check_eq("data", data_out, ed);
        check_eq("count", count, q.size());
        check_eq("ack_out", ack_out, q.size() < D);

        push = send_in && (q.size() < D);
        e    = '{data: data_in, br: br, bc: bc};
        acc  = es & ack_in;
        pop  = 0;
        if (q.size() > 0) begin
            if (ee) begin
                pop = 1;
            end else if (q[0].bc) begin
                if ((done_m | acc) == 4'hF) begin
                    pop    = 1;
                    done_m = '0;
                end else begin
                    done_m = done_m | acc;
                end
            end else begin
                pop = (acc != 0);
            end
        end
        @(posedge CLK);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
        @(negedge CLK);
    endtask

    initial begin
        done_m = '0;
        MR     = 1'b1;
        drive(1, 8'hEE, 2'd1, 0, 4'h0);
        s3_send = 0; s3_data = '0; s3_br = '0; s3_bc = 0; s3_ack_in = '0;

        // Reset held with a pending offer: nothing may be written.
        repeat (2) @(negedge CLK);
        check_eq("r33_send", send_out, 0);
        check_eq("r33_ack", ack_out, 1);
        check_eq("r33_count", count, 0);
        check_eq("r33_err", err, 0);
        MR = 1'b0;
        send_in = 0;
        step(0);
        check_eq("r33_nowrite", count, 0);

        // Unicast
        drive(1, 8'hA5, 2'd2, 0, 4'h0);
        step(0);
        send_in = 0;
        check_eq("r34_send", send_out, 4'b0100);
        check_eq("r34_data", data_out, 8'hA5);
        ack_in = 4'b0100;
        step(0);
        ack_in = 4'b0000;
        check_eq("r34_send_after", send_out, 0);
        check_eq("r34_count_after", count, 0);

        // Full and ordering
        for (int i = 1; i <= 5; i++) begin
            drive(1, 8'(i), 2'd0, 0, 4'h0);
            step(0);
        end
        send_in = 0;
        check_eq("r35_count_full", count, 4);
        check_eq("r35_ack_full", ack_out, 0);
        ack_in = 4'b0001;
        for (int i = 1; i <= 4; i++) begin
            check_eq("r35_order", data_out, i);
            step(0);
        end
        check_eq("r35_count_empty", count, 0);

        // Broadcast with staggered acks
        drive(1, 8'h3C, 2'd0, 1, 4'h0);
        step(0);
        send_in = 0;
        check_eq("r36_s0", send_out, 4'b1111);
        ack_in = 4'b0001;
        step(0);
        check_eq("r36_s1", send_out, 4'b1110);
        ack_in = 4'b0110;
        step(0);
        check_eq("r36_s2", send_out, 4'b1000);
        check_eq("r36_cnt2", count, 1);
        ack_in = 4'b1000;
        step(0);
        ack_in = 4'b0000;
        check_eq("r36_s3", send_out, 4'b0000);
        check_eq("r36_cnt3", count, 0);

        // Reset mid-broadcast
        drive(1, 8'h21, 2'd0, 1, 4'h0);
        step(0);
        drive(1, 8'h22, 2'd0, 0, 4'h0);
        step(0);
        drive(0, 8'h00, 2'd0, 0, 4'b0101);
        step(0);
        ack_in = 4'h0;
        check_eq("r38_cnt", count, 2);
        check_eq("r38_done", send_out, 4'b1010);
        step(1);
        drive(1, 8'h11, 2'd3, 0, 4'h0);
        step(0);
        send_in = 0;
        check_eq("r38_send", send_out, 4'b1000);
        check_eq("r38_data", data_out, 8'h11);
        ack_in = 4'b1000;
        step(0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 2) != 0, 8'($urandom), 2'($urandom), $urandom_range(0, 3) == 0,
                  4'($urandom));
            step($urandom_range(0, 79) == 0);
        end
        drive(0, 8'h00, 2'd0, 0, 4'h0);

        // Invalid selector on the three-channel instance
        MR = 1'b1;
        #1 MR = 1'b0;
        @(negedge CLK);
        s3_send = 1; s3_data = 8'h55; s3_br = 2'd3; s3_bc = 0;
        @(negedge CLK);
        s3_data = 8'h77; s3_br = 2'd1;
        check_eq("r37_err", s3_err, 1);
        check_eq("r37_send0", s3_send_out, 3'b000);
        @(negedge CLK);
        s3_send = 0;
        check_eq("r37_err_clr", s3_err, 0);
        check_eq("r37_send1", s3_send_out, 3'b010);
        check_eq("r37_data", s3_data_out, 8'h77);
        check_eq("r37_count", s3_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cb_n_branch.md
CB_N_BRANCH -- requirements
Module: cb_n_branch

Interface
REQ-001 Parameter DATA_W, default 8, data payload width in bits.
REQ-002 Parameter N_OUT, default 4, number of output channels, range 2..16.
REQ-003 Parameter DEPTH, default 4, input buffer entries, a power of two, at least 2.
REQ-004 Parameter SEL_W, default $clog2(N_OUT), width of the branch selector.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-006 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-007 MR  in  1  master reset, asynchronous, active-high.
REQ-008 CB_Send_in  in  1  upstream offers a word.
REQ-009 CB_Data_in  in  DATA_W  offered payload.
REQ-010 CB_Br  in  SEL_W  destination channel, captured with the payload.
REQ-011 CB_Bc  in  1  broadcast flag, captured with the payload; 1 = deliver to all channels.
REQ-012 CB_Ack_out  out  1  block can accept a word.
REQ-013 CB_Send_out  out  N_OUT  per-channel offer of the head word.
REQ-014 CB_Data_out  out  DATA_W  head payload, shared by all channels.
REQ-015 CB_Ack_in  in  N_OUT  per-channel accept.
REQ-016 CB_Err  out  1  the head entry has an out-of-range selector and is being discarded.
REQ-017 CB_Count  out  $clog2(DEPTH)+1  buffer occupancy.

Function
REQ-018 Input transfer SHALL occur on a rising edge where CB_Send_in=1 and CB_Ack_out=1; {Data, Br, Bc} are written at the tail.
REQ-019 CB_Ack_out SHALL equal (CB_Count < DEPTH) and SHALL be driven from registered state only, with no combinational path from CB_Send_in.
REQ-020 The buffer SHALL be a circular FIFO; head and tail pointers wrap modulo DEPTH.
REQ-021 Latency SHALL be one cycle: a word written into an empty buffer is offered in the following cycle; there is no same-cycle pass-through.
REQ-022 CB_Data_out SHALL show the head payload whenever CB_Count>0, and 0 when the buffer is empty.
REQ-023 Unicast head (Bc=0, Br<N_OUT): CB_Send_out SHALL be one-hot on bit Br; the entry pops on the edge where CB_Ack_in[Br]=1.
REQ-024 Ack on a channel whose CB_Send_out bit is 0 SHALL be ignored.
REQ-025 Broadcast head (Bc=1): CB_Send_out[i] = ~done[i] for every channel i.
  - done[i] sets on each edge where CB_Send_out[i]&CB_Ack_in[i].
  - Channels may accept in different cycles or together.
  - The entry pops on the edge where (done | accepted) becomes all ones; done clears to 0 on that same edge.
REQ-026 An offered word, and its Send bits, SHALL stay stable until accepted; Send bits are never withdrawn.
REQ-027 Invalid head (Bc=0, Br>=N_OUT):
  - CB_Send_out=0 and CB_Err=1 for exactly one cycle.
  - The entry pops on the next edge.
  - Not reachable when N_OUT is a power of two; the logic SHALL still be present.
REQ-028 Simultaneous push and pop in one edge SHALL leave CB_Count unchanged. Otherwise CB_Count changes by +1 on a push alone and by -1 on a pop alone.
REQ-029 When the buffer is full, pushes are refused (CB_Ack_out=0); a pop on that edge does not enable a same-edge push.
REQ-030 CB_Send_out, CB_Err and CB_Data_out SHALL be derived combinationally from registered state only.

Reset
REQ-031 While MR=1, the following SHALL be held, with no clock required:
  - CB_Send_out=0 and CB_Err=0.
  - CB_Count=0 and CB_Ack_out=1.
  - CB_Data_out=0.
  - Pointers and the done mask cleared.
REQ-032 MR asserted mid-operation SHALL discard all buffered and partially broadcast words; after MR falls, the first push is delivered normally.

Verification (DATA_W=8, N_OUT=4, DEPTH=4 unless stated)
REQ-033 Reset: assert MR with CB_Send_in=1 -> Send_out=0000, Ack_out=1, Count=0, Err=0; no write occurs.
REQ-034 Unicast: push 0xA5 with Br=2 -> next cycle Send_out=0100, Data_out=0xA5; Ack_in=0100 for one edge -> Send_out=0000, Count=0.
REQ-035 Full and ordering: hold Ack_in=0000 and push 0x01..0x04 to Br=0 -> Count=4, Ack_out=0; a push of 0x05 is refused. Then Ack_in=0001 -> outputs 0x01,0x02,0x03,0x04 in order and Count reaches 0.
REQ-036 Broadcast: push 0x3C with Bc=1; apply Ack_in=0001, then 0110, then 1000 -> Send_out goes 1111, 1110, 1000, 0000; the pop occurs on the third ack edge.
REQ-037 Invalid selector (N_OUT=3, SEL_W=2): push Br=3 followed by 0x77 to Br=1 -> Err=1 for one cycle with Send_out=000; next cycle Send_out=010, Data_out=0x77.
REQ-038 Reset mid-operation: with Count=2 and broadcast done=0101, assert MR asynchronously -> outputs clear within the same cycle; after release, push 0x11 to Br=3 -> Send_out=1000.
